// File: rtl/rom_loader_mc_if.sv
// SDRAM write-port bundle between the ROM loader and the SDRAM channel.
// The loader drives the word and request; the channel returns a completion pulse.
interface rom_loader_mc_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 25
);
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] be;
    logic                req;
    logic                rdy;

    modport master (
        output addr,
        output data,
        output be,
        output req,
        input  rdy
    );

    modport slave (
        input  addr,
        input  data,
        input  be,
        input  req,
        output rdy
    );
endinterface

// File: rtl/rom_loader_mc.sv
// ioctl byte stream to SDRAM word packer with FIFO-buffered issue engine,
// plus a registered byte path into one-hot selected BRAM regions.
module rom_loader_mc #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 25,
    parameter logic [ADDR_W-1:0] SDR_LIMIT = ADDR_W'(32'h0010_0000),
    parameter int                NUM_BRAM  = 6,
    parameter int                BRAM_AW   = 16,
    parameter int                FIFO_AW   = 2
) (
    input  logic                clk,
    input  logic                RSTn,
    input  logic                ioctl_download,
    input  logic                ioctl_wr,
    input  logic [ADDR_W-1:0]   ioctl_addr,
    input  logic [7:0]          ioctl_data,
    output logic                ioctl_wait,
    rom_loader_mc_if.master     sdr,
    output logic [BRAM_AW-1:0]  bram_addr,
    output logic [7:0]          bram_data,
    output logic [NUM_BRAM-1:0] bram_cs,
    output logic                bram_wr,
    output logic                load_done,
    output logic [1:0]          err
);

    localparam int BYTES = DATA_W / 8;
    localparam int LW    = $clog2(BYTES);
    localparam int WW    = ADDR_W - LW;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [63:0] BRAM_END =
        64'(SDR_LIMIT) + (64'(NUM_BRAM) << BRAM_AW);

    typedef struct packed {
        logic [WW-1:0]     w;
        logic [DATA_W-1:0] data;
        logic [BYTES-1:0]  be;
    } word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_t;

    // ---------------- decode ----------------
    logic                accept;
    logic                in_sdr;
    logic                in_bram;
    logic                sdr_byte;
    logic                bram_byte;
    logic                bad_byte;
    logic [ADDR_W-1:0]   boff;
    logic [NUM_BRAM-1:0] region_cs;
    logic [WW-1:0]       w_in;
    logic [LW-1:0]       lane;

    assign accept    = ioctl_download & ioctl_wr;
    assign in_sdr    = ioctl_addr < SDR_LIMIT;
    assign in_bram   = !in_sdr && (64'(ioctl_addr) < BRAM_END);
    assign sdr_byte  = accept & in_sdr;
    assign bram_byte = accept & in_bram;
    assign bad_byte  = accept & !in_sdr & !in_bram;
    assign boff      = ioctl_addr - SDR_LIMIT;
    assign w_in      = ioctl_addr[ADDR_W-1:LW];
    assign lane      = ioctl_addr[LW-1:0];

    always_comb begin
        region_cs = '0;
        for (int i = 0; i < NUM_BRAM; i++) begin
            if ((boff >> BRAM_AW) == ADDR_W'(i))
                region_cs[i] = 1'b1;
        end
    end

    // ---------------- download edges ----------------
    logic dl_q;
    logic dl_rise;
    logic dl_fall;

    assign dl_rise = ioctl_download & !dl_q;
    assign dl_fall = dl_q & !ioctl_download;

    // ---------------- packer ----------------
    word_t pk;
    word_t pk_nx;
    word_t merged;
    word_t fl;
    word_t fl_nx;
    logic  fl_v;
    logic  fl_v_nx;
    logic  fresh;

    assign fresh = (pk.be != '0) && (pk.w != w_in);

    // A byte for another word starts from a blank word; the old one is staged.
    always_comb begin
        merged = fresh ? '0 : pk;
        merged.w = w_in;
        for (int k = 0; k < BYTES; k++) begin
            if (lane == LW'(k)) begin
                merged.data[8*k +: 8] = ioctl_data;
                merged.be[k]          = 1'b1;
            end
        end
    end

    always_comb begin
        pk_nx   = pk;
        fl_nx   = pk;
        fl_v_nx = 1'b0;
        if (sdr_byte) begin
            if (fresh) begin
                fl_v_nx = 1'b1;
                pk_nx   = merged;
            end else if (&merged.be) begin
                fl_v_nx = 1'b1;
                fl_nx   = merged;
                pk_nx   = '0;
            end else begin
                pk_nx   = merged;
            end
        end else if ((bram_byte || dl_fall) && pk.be != '0) begin
            fl_v_nx = 1'b1;
            pk_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            pk   <= '0;
            fl   <= '0;
            fl_v <= 1'b0;
            dl_q <= 1'b0;
        end else begin
            pk   <= pk_nx;
            fl   <= fl_nx;
            fl_v <= fl_v_nx;
            dl_q <= ioctl_download;
        end
    end

    // ---------------- FIFO ----------------
    word_t              mem [DEPTH];
    word_t              head;
    logic [FIFO_AW-1:0] wp;
    logic [FIFO_AW-1:0] rp;
    logic [CW-1:0]      count;
    logic               full;
    logic               pop;
    logic               do_push;
    logic               ovf;
    state_t             state;
    state_t             state_nx;
    logic               load;

    assign head    = mem[rp];
    assign full    = count == CW'(DEPTH);
    assign pop     = (state == BUSY) && sdr.rdy;
    assign do_push = fl_v && (!full || pop);
    assign ovf     = fl_v && full && !pop;

    assign ioctl_wait = count >= CW'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= fl;
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            unique case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk) begin
        if (!RSTn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    load     = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (sdr.rdy)
                    state_nx = GAP;
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign sdr.req = (state == BUSY);

    // The head entry stays in the FIFO until completion; these hold its copy.
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            sdr.addr <= '0;
            sdr.data <= '0;
            sdr.be   <= '0;
        end else if (load) begin
            sdr.addr <= {head.w, {LW{1'b0}}};
            sdr.data <= head.data;
            sdr.be   <= head.be;
        end
    end

    // ---------------- BRAM path ----------------
    always_ff @(posedge clk) begin
        if (!RSTn) begin
            bram_wr   <= 1'b0;
            bram_cs   <= '0;
            bram_addr <= '0;
            bram_data <= '0;
        end else begin
            bram_wr <= bram_byte;
            bram_cs <= bram_byte ? region_cs : '0;
            if (bram_byte) begin
                bram_addr <= boff[BRAM_AW-1:0];
                bram_data <= ioctl_data;
            end
        end
    end

    // ---------------- status ----------------
    logic drained;

    assign drained = !ioctl_download && (pk.be == '0) && !fl_v &&
                     (count == '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            load_done <= 1'b0;
            err       <= 2'b00;
        end else begin
            if (dl_rise)
                load_done <= 1'b0;
            else if (drained)
                load_done <= 1'b1;
            err <= (dl_rise ? 2'b00 : err) | {ovf, bad_byte};
        end
    end

endmodule

// File: tb/tb_rom_loader_mc.sv
// Directed bench for rom_loader_mc (DATA_W=16, DEPTH=4, six 64 KiB BRAM regions).
module tb_rom_loader_mc;

    logic        clk = 1'b0;
    logic        RSTn = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wait;
    logic [15:0] bram_addr;
    logic [7:0]  bram_data;
    logic [5:0]  bram_cs;
    logic        bram_wr;
    logic        load_done;
    logic [1:0]  err;

    rom_loader_mc_if #(.DATA_W(16), .ADDR_W(25)) sdr();

    rom_loader_mc #(
        .DATA_W(16),
        .ADDR_W(25),
        .SDR_LIMIT(25'h0100000),
        .NUM_BRAM(6),
        .BRAM_AW(16),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .RSTn(RSTn),
        .ioctl_download(ioctl_download),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data),
        .ioctl_wait(ioctl_wait),
        .sdr(sdr),
        .bram_addr(bram_addr),
        .bram_data(bram_data),
        .bram_cs(bram_cs),
        .bram_wr(bram_wr),
        .load_done(load_done),
        .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit auto_rdy = 1'b0;

    logic [24:0] q_addr [$];
    logic [15:0] q_data [$];
    logic [1:0]  q_be   [$];

    // SDRAM model: one-cycle completion pulse for every request, logging the word.
    always @(negedge clk) begin
        if (auto_rdy) begin
            if (sdr.req && !sdr.rdy) begin
                sdr.rdy = 1'b1;
                q_addr.push_back(sdr.addr);
                q_data.push_back(sdr.data);
                q_be.push_back(sdr.be);
            end else begin
                sdr.rdy = 1'b0;
            end
        end
    end

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        q_be.delete();
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_data = d;
        @(posedge clk);
        #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic start_download();
        @(negedge clk);
        ioctl_download = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic end_download();
        @(negedge clk);
        ioctl_download = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (load_done !== 1'b1 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL %s load_done timeout got %b want 1", tag, load_done);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({sdr.req, sdr.addr, sdr.data, sdr.be} !== '0) begin
            errors++;
            $display("FAIL reset_sdr got req=%b addr=%h data=%h be=%b want 0",
                     sdr.req, sdr.addr, sdr.data, sdr.be);
        end
        checks++;
        if ({ioctl_wait, load_done, err, bram_wr, bram_cs} !== '0) begin
            errors++;
            $display("FAIL reset_status got wait=%b done=%b err=%b wr=%b cs=%b want 0",
                     ioctl_wait, load_done, err, bram_wr, bram_cs);
        end
    endtask

    task automatic test_pack_full();
        clear_log();
        auto_rdy = 1'b1;
        start_download();
        send_byte(25'h0, 8'h11);
        send_byte(25'h1, 8'h22);
        @(posedge clk);
        #1;
        checks++;
        if (sdr.req !== 1'b0) begin
            errors++;
            $display("FAIL latency_t1 got req=%b want 0", sdr.req);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sdr.req !== 1'b1) begin
            errors++;
            $display("FAIL latency_t2 got req=%b want 1", sdr.req);
        end
        end_download();
        wait_done("pack_full");
        checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 25'h0 ||
            q_data[0] !== 16'h2211 || q_be[0] !== 2'b11) begin
            errors++;
            $display("FAIL pack_full got n=%0d addr=%h data=%h be=%b want 1 0 2211 11",
                     q_addr.size(), q_addr[0], q_data[0], q_be[0]);
        end
    endtask

    task automatic test_partial();
        clear_log();
        start_download();
        send_byte(25'h3, 8'hAA);
        send_byte(25'h6, 8'hBB);
        end_download();
        wait_done("partial");
        checks++;
        if (q_addr.size() != 2) begin
            errors++;
            $display("FAIL partial_count got %0d want 2", q_addr.size());
        end else begin
            checks++;
            if (q_addr[0] !== 25'h2 || q_data[0] !== 16'hAA00 || q_be[0] !== 2'b10) begin
                errors++;
                $display("FAIL partial_w0 got addr=%h data=%h be=%b want 2 aa00 10",
                         q_addr[0], q_data[0], q_be[0]);
            end
            checks++;
            if (q_addr[1] !== 25'h6 || q_data[1] !== 16'h00BB || q_be[1] !== 2'b01) begin
                errors++;
                $display("FAIL partial_w1 got addr=%h data=%h be=%b want 6 00bb 01",
                         q_addr[1], q_data[1], q_be[1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc = 0;
        int sent = 0;
        int first = -1;
        clear_log();
        start_download();
        auto_rdy = 1'b0;
        while (sent < 16 && cyc < 400) begin
            @(negedge clk);
            if (cyc == 50)
                auto_rdy = 1'b1;
            if (ioctl_wait && first < 0)
                first = sent;
            if (!ioctl_wait) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'h100 + 25'(sent);
                ioctl_data = 8'h30 + 8'(sent);
                sent++;
            end
            @(posedge clk);
            #1;
            ioctl_wr = 1'b0;
            cyc++;
        end
        auto_rdy = 1'b1;
        checks++;
        if (sent != 16) begin
            errors++;
            $display("FAIL bp_stream got sent=%0d want 16", sent);
        end
        checks++;
        if (first != 7) begin
            errors++;
            $display("FAIL bp_wait_rise got bytes=%0d want 7", first);
        end
        end_download();
        wait_done("backpressure");
        checks++;
        if (q_addr.size() != 8 || err !== 2'b00) begin
            errors++;
            $display("FAIL bp_words got n=%0d err=%b want 8 00", q_addr.size(), err);
        end
        for (int i = 0; i < q_addr.size() && i < 8; i++) begin
            logic [24:0] ea;
            logic [15:0] ed;
            ea = 25'h100 + 25'(2 * i);
            ed = {8'h30 + 8'(2 * i + 1), 8'h30 + 8'(2 * i)};
            checks++;
            if (q_addr[i] !== ea || q_data[i] !== ed || q_be[i] !== 2'b11) begin
                errors++;
                $display("FAIL bp_word%0d got addr=%h data=%h be=%b want %h %h 11",
                         i, q_addr[i], q_data[i], q_be[i], ea, ed);
            end
        end
    endtask

    task automatic test_bram();
        clear_log();
        start_download();
        send_byte(25'h10, 8'h77);
        send_byte(25'h0100000 + (25'd2 << 16) + 25'd7, 8'h5C);
        checks++;
        if (bram_wr !== 1'b1 || bram_cs !== 6'b000100 ||
            bram_addr !== 16'h0007 || bram_data !== 8'h5C) begin
            errors++;
            $display("FAIL bram_write got wr=%b cs=%b addr=%h data=%h want 1 000100 0007 5c",
                     bram_wr, bram_cs, bram_addr, bram_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bram_wr !== 1'b0 || bram_cs !== 6'b0) begin
            errors++;
            $display("FAIL bram_pulse got wr=%b cs=%b want 0 000000", bram_wr, bram_cs);
        end
        send_byte(25'h0100000 + (25'd6 << 16), 8'hEE);
        checks++;
        if (err !== 2'b01 || bram_wr !== 1'b0) begin
            errors++;
            $display("FAIL bram_range got err=%b wr=%b want 01 0", err, bram_wr);
        end
        end_download();
        wait_done("bram");
        checks++;
        if (q_addr.size() != 1 || q_addr[0] !== 25'h10 ||
            q_data[0] !== 16'h0077 || q_be[0] !== 2'b01) begin
            errors++;
            $display("FAIL bram_flush got n=%0d addr=%h data=%h be=%b want 1 10 0077 01",
                     q_addr.size(), q_addr[0], q_data[0], q_be[0]);
        end
    endtask

    task automatic test_reset_busy();
        int n = 0;
        bit seen = 1'b0;
        clear_log();
        start_download();
        auto_rdy = 1'b0;
        send_byte(25'h200, 8'h01);
        send_byte(25'h201, 8'h02);
        send_byte(25'h202, 8'h03);
        send_byte(25'h203, 8'h04);
        while (sdr.req !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sdr.req !== 1'b1) begin
            errors++;
            $display("FAIL rst_busy_req got %b want 1", sdr.req);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        RSTn = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sdr.req !== 1'b0 || sdr.addr !== '0 || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_clear got req=%b addr=%h wait=%b want 0 0 0",
                     sdr.req, sdr.addr, ioctl_wait);
        end
        @(negedge clk);
        RSTn = 1'b1;
        auto_rdy = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (sdr.req === 1'b1)
                seen = 1'b1;
        end
        checks++;
        if (seen || q_addr.size() != 0) begin
            errors++;
            $display("FAIL rst_busy_quiet got req_seen=%b writes=%0d want 0 0",
                     seen, q_addr.size());
        end
        end_download();
        wait_done("reset_busy");
    endtask

    task automatic test_done();
        int n = 0;
        auto_rdy = 1'b1;
        start_download();
        send_byte(25'h1FFFFFF, 8'h99);
        end_download();
        wait_done("done_err");
        checks++;
        if (err !== 2'b01) begin
            errors++;
            $display("FAIL done_err_sticky got %b want 01", err);
        end
        start_download();
        checks++;
        if (load_done !== 1'b0 || err !== 2'b00) begin
            errors++;
            $display("FAIL done_rise_clear got done=%b err=%b want 0 00", load_done, err);
        end
        auto_rdy = 1'b0;
        send_byte(25'h300, 8'hA1);
        send_byte(25'h301, 8'hA2);
        end_download();
        while (sdr.req !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sdr.req !== 1'b1 || load_done !== 1'b0 ||
            sdr.addr !== 25'h300 || sdr.data !== 16'hA2A1) begin
            errors++;
            $display("FAIL done_pending got req=%b done=%b addr=%h data=%h want 1 0 300 a2a1",
                     sdr.req, load_done, sdr.addr, sdr.data);
        end
        @(negedge clk);
        sdr.rdy = 1'b1;
        @(posedge clk);
        #1;
        sdr.rdy = 1'b0;
        checks++;
        if (sdr.req !== 1'b0 || load_done !== 1'b0) begin
            errors++;
            $display("FAIL done_after_rdy got req=%b done=%b want 0 0", sdr.req, load_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_done !== 1'b0) begin
            errors++;
            $display("FAIL done_gap got %b want 0", load_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (load_done !== 1'b1) begin
            errors++;
            $display("FAIL done_set got %b want 1", load_done);
        end
    endtask

    initial begin
        sdr.rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        RSTn = 1'b1;
        test_pack_full();
        test_partial();
        test_backpressure();
        test_bram();
        test_reset_busy();
        test_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
